spi_arb: RTL

SPI_ARB -- requirements
Module: spi_arb

---
 rtl/spi_arb.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/spi_arb.sv
// Two-port round-robin arbiter in front of a single SPI master. Each granted
// request gets one command byte out, two read bytes back, with a timeout guard.
module spi_arb #(
   parameter int GAP_CYCLES = 16,
   parameter int TIMEOUT    = 8192
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ0,
   input  logic        REQ1,
   input  logic [7:0]  CMD0,
   input  logic [7:0]  CMD1,
   output logic        DONE0,
   output logic        DONE1,
   output logic        ERR0,
   output logic        ERR1,
   output logic [15:0] RDATA0,
   output logic [15:0] RDATA1,
   output logic        BUSY,
   output logic        SPI_START,
   output logic [7:0]  SPI_TXDATA,
   input  logic        SPI_CS_N,
   input  logic [7:0]  SPI_RX1,
   input  logic [7:0]  SPI_RX2
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WAIT_LO,
      S_WAIT_HI,
      S_DONE,
      S_GAP
   } state_t;

   localparam logic [13:0] TO_LAST  = 14'(TIMEOUT - 1);
   localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);

   state_t      state_q;
   logic        gnt_q;
   logic        last_q;
   logic [13:0] to_cnt_q;
   logic [7:0]  gap_cnt_q;
   logic        done0_q;
   logic        done1_q;
   logic        err0_q;
   logic        err1_q;
   logic [15:0] rdata0_q;
   logic [15:0] rdata1_q;
   logic        busy_q;
   logic        spi_start_q;
   logic [7:0]  txdata_q;

   logic        gnt_d;
   logic [7:0]  cmd_d;
   logic        to_hit;
   logic        fin_ok;
   logic        fin_to;

   // With both requests pending the port not served last wins; otherwise the lone requester wins.
   always_comb begin
      gnt_d  = (REQ0 && REQ1) ? ~last_q : REQ1;
      cmd_d  = gnt_d ? CMD1 : CMD0;
      to_hit = (to_cnt_q == TO_LAST);
      fin_ok = (state_q == S_WAIT_HI) && SPI_CS_N;
      fin_to = to_hit && (((state_q == S_WAIT_LO) && SPI_CS_N) ||
                          ((state_q == S_WAIT_HI) && !SPI_CS_N));
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= S_IDLE;
         gnt_q       <= 1'b0;
         last_q      <= 1'b1;
         to_cnt_q    <= '0;
         gap_cnt_q   <= '0;
         done0_q     <= 1'b0;
         done1_q     <= 1'b0;
         err0_q      <= 1'b0;
         err1_q      <= 1'b0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         busy_q      <= 1'b0;
         spi_start_q <= 1'b0;
         txdata_q    <= '0;
      end else begin
         spi_start_q <= 1'b0;
         done0_q     <= 1'b0;
         done1_q     <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (REQ0 || REQ1) begin
                  gnt_q       <= gnt_d;
                  txdata_q    <= cmd_d;
                  spi_start_q <= 1'b1;
                  busy_q      <= 1'b1;
                  state_q     <= S_START;
               end
            end
            S_START: begin
               to_cnt_q <= '0;
               state_q  <= S_WAIT_LO;
            end
            S_WAIT_LO, S_WAIT_HI: begin
               // Completion outputs are written on entry to DONE so they are visible during it.
               if (fin_ok || fin_to) begin
                  state_q <= S_DONE;
                  if (gnt_q) begin
                     done1_q <= 1'b1;
                     err1_q  <= fin_to;
                     if (fin_ok) rdata1_q <= {SPI_RX1, SPI_RX2};
                  end else begin
                     done0_q <= 1'b1;
                     err0_q  <= fin_to;
                     if (fin_ok) rdata0_q <= {SPI_RX1, SPI_RX2};
                  end
               end else if ((state_q == S_WAIT_LO) && !SPI_CS_N) begin
                  to_cnt_q <= '0;
                  state_q  <= S_WAIT_HI;
               end else begin
                  to_cnt_q <= to_cnt_q + 14'd1;
               end
            end
            S_DONE: begin
               last_q    <= gnt_q;
               gap_cnt_q <= '0;
               state_q   <= S_GAP;
            end
            S_GAP: begin
               if (gap_cnt_q == GAP_LAST) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  gap_cnt_q <= gap_cnt_q + 8'd1;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign DONE0      = done0_q;
   assign DONE1      = done1_q;
   assign ERR0       = err0_q;
   assign ERR1       = err1_q;
   assign RDATA0     = rdata0_q;
   assign RDATA1     = rdata1_q;
   assign BUSY       = busy_q;
   assign SPI_START  = spi_start_q;
   assign SPI_TXDATA = txdata_q;

endmodule
